// File: rtl/shift_frame_receiver.sv
// Deserializer for one framed 4-bit word (start, 4 data, stop) with a valid strobe or framing-error pulse.
// Optional PWR_CNT_EN adds pwr_cnt, a saturating count of q rising bits reported to power-counter slot PwrC.
module shift_frame_receiver #(
  parameter int   PwrC       = 0,
  parameter logic STOP_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_in,
  input  logic        s_valid,
  input  logic        dir,
  output logic [3:0]  q,
  output logic        q_valid,
  output logic        busy,
`ifdef PWR_CNT_EN
  output logic [15:0] pwr_cnt,
`endif
  output logic        frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [3:0]  sh_r, sh_s;
  logic        dir_r, dir_s;
  logic [3:0]  q_r, q_s;
  logic        q_valid_r, q_valid_s;
  logic        frame_err_r, frame_err_s;
  logic        busy_r, busy_s;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Slot indices are non-negative; reject a bad value when the design is built.
  if (PwrC < 0) begin : g_pwrc_check
    $error("PwrC must be non-negative");
  end

`ifdef PWR_CNT_EN
  logic [15:0] pwr_cnt_r, pwr_cnt_s;
  logic [16:0] pwr_sum_s;

  // Saturating accumulation of 0->1 transitions on q whenever q is reloaded.
  always_comb begin
    pwr_cnt_s = pwr_cnt_r;
    pwr_sum_s = {1'b0, pwr_cnt_r} + {14'd0, popcount4(~q_r & sh_r)};
    if (q_valid_s) begin
      if (pwr_sum_s[16]) begin
        pwr_cnt_s = 16'hFFFF;
      end else begin
        pwr_cnt_s = pwr_sum_s[15:0];
      end
    end else begin
      pwr_cnt_s = pwr_cnt_r;
    end
  end

  // Power counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwr_cnt_r <= 16'd0;
    end else begin
      pwr_cnt_r <= pwr_cnt_s;
    end
  end

  assign pwr_cnt = pwr_cnt_r;
`endif

  // Next-state and output decode; pulses default low so they last one cycle only.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    sh_s        = sh_r;
    dir_s       = dir_r;
    q_s         = q_r;
    q_valid_s   = 1'b0;
    frame_err_s = 1'b0;
    busy_s      = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (s_valid && (s_in == 1'b0)) begin
          state_s = ST_DATA;
          dir_s   = dir;
          cnt_s   = 2'd0;
          sh_s    = 4'd0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (s_valid) begin
          // MSB-first shifts left; LSB-first shifts right so the first bit ends in bit 0.
          if (dir_r) begin
            sh_s = {sh_r[2:0], s_in};
          end else begin
            sh_s = {s_in, sh_r[3:1]};
          end
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (s_valid) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          if (s_in == STOP_LEVEL) begin
            q_s       = sh_r;
            q_valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      sh_r        <= 4'd0;
      dir_r       <= 1'b0;
      q_r         <= 4'd0;
      q_valid_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sh_r        <= sh_s;
      dir_r       <= dir_s;
      q_r         <= q_s;
      q_valid_r   <= q_valid_s;
      frame_err_r <= frame_err_s;
      busy_r      <= busy_s;
    end
  end

  assign q         = q_r;
  assign q_valid   = q_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Directed bench for shift_frame_receiver; define PWR_CNT_EN to also check pwr_cnt.
module tb_shift_frame_receiver;

  logic        clk;
  logic        reset;
  logic        s_in;
  logic        s_valid;
  logic        dir;
  logic [3:0]  q;
  logic        q_valid;
  logic        busy;
  logic        frame_err;
`ifdef PWR_CNT_EN
  logic [15:0] pwr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  shift_frame_receiver #(.PwrC(0), .STOP_LEVEL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .dir       (dir),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy),
`ifdef PWR_CNT_EN
    .pwr_cnt   (pwr_cnt),
`endif
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input on the falling edge, return 1 time unit after the rising edge.
  task automatic send(input logic v, input logic b);
    @(negedge clk);
    s_valid = v;
    s_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({q, q_valid, busy, frame_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {q, q_valid, busy, frame_err}, 7'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    send(1'b1, 1'b1);
    checks++;
    if ({q, q_valid, busy, frame_err} !== 7'd0) begin
      errors++;
      $display("FAIL idle_outputs got %b want %b", {q, q_valid, busy, frame_err}, 7'd0);
    end
  endtask

  task automatic test_msb_first();
    logic [5:0] seq = 6'b010111;
    int qv = 0;
    dir = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      send(1'b1, seq[i]);
      if (i == 4) dir = 1'b0;
      qv += int'(q_valid);
    end
    checks++;
    if (q !== 4'b1011 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL msb_q got %b/%b want 1011/1", q, q_valid);
    end
    send(1'b1, 1'b1);
    checks++;
    if (q_valid !== 1'b0 || qv != 1) begin
      errors++;
      $display("FAIL msb_pulse got valid=%b count=%0d want 0/1", q_valid, qv);
    end
  endtask

  task automatic test_lsb_first();
    logic [5:0] seq = 6'b010111;
    int bc = 0;
    int qv = 0;
    dir = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      send(1'b1, seq[i]);
      bc += int'(busy);
      qv += int'(q_valid);
      if (i == 5) begin
        checks++;
        if (busy !== 1'b1 || q_valid !== 1'b0) begin
          errors++;
          $display("FAIL lsb_start got busy=%b valid=%b want 1/0", busy, q_valid);
        end
      end
    end
    checks++;
    if (q !== 4'b1101 || q_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lsb_q got q=%b valid=%b busy=%b want 1101/1/0", q, q_valid, busy);
    end
    send(1'b1, 1'b1);
    bc += int'(busy);
    qv += int'(q_valid);
    checks++;
    if (bc != 5 || qv != 1) begin
      errors++;
      $display("FAIL lsb_counts got busy=%0d valid=%0d want 5/1", bc, qv);
    end
  endtask

  task automatic test_bad_stop();
    logic [5:0] seq = 6'b011110;
    dir = 1'b0;
    for (int i = 5; i >= 0; i--) send(1'b1, seq[i]);
    checks++;
    if (frame_err !== 1'b1 || q_valid !== 1'b0 || q !== 4'b1101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop got err=%b valid=%b q=%b busy=%b want 1/0/1101/0", frame_err, q_valid, q, busy);
    end
    send(1'b1, 1'b1);
    checks++;
    if (frame_err !== 1'b0 || q !== 4'b1101) begin
      errors++;
      $display("FAIL bad_stop_after got err=%b q=%b want 0/1101", frame_err, q);
    end
  endtask

  task automatic test_stall();
    int edges = 0;
    int qv = 0;
    int at = 0;
    dir = 1'b0;
    send(1'b1, 1'b0); edges++;
    send(1'b1, 1'b1); edges++;
    send(1'b1, 1'b0); edges++;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, i[0]); edges++;
      checks++;
      if (busy !== 1'b1 || q_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got busy=%b valid=%b want 1/0", busy, q_valid);
      end
    end
    send(1'b1, 1'b0); edges++;
    send(1'b1, 1'b1); edges++;
    send(1'b1, 1'b1); edges++;
    qv += int'(q_valid);
    if (q_valid === 1'b1) at = edges;
    send(1'b0, 1'b1);
    qv += int'(q_valid);
    send(1'b0, 1'b1);
    qv += int'(q_valid);
    checks++;
    if (q !== 4'b1001 || at != 9 || qv != 1) begin
      errors++;
      $display("FAIL stall got q=%b edges=%0d pulses=%0d want 1001/9/1", q, at, qv);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] seq = 6'b001101;
    dir = 1'b0;
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({q, q_valid, busy, frame_err} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b want %b", {q, q_valid, busy, frame_err}, 7'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 5; i >= 0; i--) send(1'b1, seq[i]);
    checks++;
    if (q !== 4'b0110 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_q got %b/%b want 0110/1", q, q_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] frames [4] = '{6'b000001, 6'b011111, 6'b000001, 6'b010101};
    logic [3:0] exp_q [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b0101};
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dir = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 5; i >= 0; i--) send(1'b1, frames[f][i]);
      checks++;
      if (q !== exp_q[f] || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_q%0d got %b/%b want %b/1", f, q, q_valid, exp_q[f]);
      end
    end
`ifdef PWR_CNT_EN
    checks++;
    if (pwr_cnt !== 16'd6) begin
      errors++;
      $display("FAIL pwr_cnt got %0d want %0d", pwr_cnt, 16'd6);
    end
`endif
    send(1'b1, 1'b1);
  endtask

  initial begin
    reset   = 1'b1;
    s_in    = 1'b1;
    s_valid = 1'b0;
    dir     = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_bad_stop();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_frame_receiver.md
Name: shift_frame_receiver

Overview:
- Receiving end of the 4-bit shift register's serial output. Deserializes one framed 4-bit word: start bit, 4 data bits, stop bit.
- Presents the word in parallel with a one-cycle valid strobe, or flags a framing error.
- Sits between the serial link driven by the 4-bit shifting register and downstream parallel logic in the testbench top.

Parameters:
- PwrC, 0, index of the power-counter slot this instance reports to; used only under the optional feature.
- STOP_LEVEL, 1, required line level of the stop bit (0 or 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_in  input  1  serial data line.
- s_valid  input  1  qualifier; s_in is sampled only on edges where s_valid=1, otherwise the FSM holds.
- dir  input  1  bit order, sampled with the start bit: 0 = LSB first, 1 = MSB first.
- q  output  4  last correctly received word.
- q_valid  output  1  one-cycle pulse when q is updated.
- busy  output  1  high while a frame is in progress (after the start bit, through the stop bit).
- frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Interface: one clock, clk. Reset is reset, asynchronous and active-high. While reset=1, all state and outputs are forced to reset values immediately, independent of clk.
- Reset values: q=4'b0000, q_valid=0, busy=0, frame_err=0, state=IDLE, bit counter=0, shift register=0, latched dir=0.
- States:
  - IDLE: on a qualified sample with s_in=0 (start bit), latch dir, clear counter and shift register, go to DATA, set busy=1. A qualified s_in=1 is line idle: stay in IDLE.
  - DATA: each qualified sample shifts s_in into the shift register.
    - dir=0: bit k lands in position k; first bit goes to q[0].
    - dir=1: first bit goes to q[3].
    - 2-bit counter increments each sample. After the 4th sample (counter wraps 3 to 0), go to STOP.
  - STOP: on a qualified sample, go to IDLE and set busy=0.
    - If s_in==STOP_LEVEL: q <= shift register, q_valid=1 for exactly that cycle.
    - Otherwise: frame_err=1 for exactly that cycle; q keeps its old value.
- Latency: q/q_valid update on the same edge that samples the stop bit. Minimum is 6 qualified edges from start bit to q_valid.
- Stalls: s_valid=0 freezes state, counter and shift register in every state. Pulses never repeat during a stall; q_valid and frame_err drop the next cycle regardless of s_valid.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge.
- dir changes mid-frame are ignored; only the value latched at the start bit is used.
- Reset mid-frame: the frame is discarded, q returns to 0, and no pulse is emitted.
- q_valid and frame_err are mutually exclusive and are never high outside the stop-sample cycle.

Optional Feature:
- Macro: PWR_CNT_EN
- Defined:
  - Adds output port pwr_cnt, 16 bits.
  - Counts rising transitions of any q bit, summed per edge (popcount of ~q_old & q_new on each q update).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - PwrC is reported as the slot index in the header comment.
- Undefined: port and counter are absent, and the behaviour of all other ports is identical.

Test Plan:
- Reset, then dir=0, s_valid=1, serial 0,1,0,1,1,1 (start, D=1,0,1,1, stop) -> q=4'b1101, q_valid high exactly 1 cycle, busy high for 5 cycles.
- Same bits with dir=1 -> q=4'b1011, q_valid single pulse.
- Frame 0,1,1,1,1,0 (bad stop, STOP_LEVEL=1) after a prior q=4'b1101 -> frame_err pulse 1 cycle, q stays 4'b1101, q_valid stays 0.
- Frame with s_valid deasserted for 3 cycles after the 2nd data bit, data 1,0,0,1, dir=0 -> q=4'b1001, total 9 edges from start to q_valid, no duplicate pulse.
- Assert reset asynchronously between clock edges after 2 data bits -> outputs 0 immediately; next full frame 0,0,1,1,0,1 with dir=0 -> q=4'b0110.
- With PWR_CNT_EN: frames producing q=0000 -> 1111 -> 0000 -> 0101 -> pwr_cnt=6; without the macro, the same stimulus compiles and q matches.
